seq_scan_ctrl: RTL and testbench



---
 rtl/seq_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-level wrapper around an overlapping "1010" Mealy detector.
//
// A word is accepted over in_valid/in_ready, shifted MSB-first through the
// detector (one bit per cycle), and the saturating match count is offered on
// out_valid/out_ready. The detector state survives between words so that
// keep=1 can detect patterns straddling a word boundary.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       word handshake (ready only in IDLE)
//   in_data [W-1:0]         word to scan, bit W-1 first
//   keep                    1: continue detector state, 0: restart at S0
//   out_valid/out_ready     result handshake
//   out_count [CW-1:0]      saturating count of matches ending in the word
//   out_hit                 out_count != 0
//   match_pulse             combinational pulse on each completed match
//   busy                    high while scanning or holding a result
module seq_scan_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          keep,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_hit,
  output logic          match_pulse,
  output logic          busy
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {DetS0, DetS1, DetS2, DetS3} det_e;

  state_e        state_q;
  det_e          det_q;
  det_e          det_d;
  logic [W-1:0]  shreg_q;
  logic [BW-1:0] bit_cnt_q;
  logic [CW-1:0] count_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          shift_bit;

  assign shift_bit = shreg_q[W-1];

  // Detector next state and Mealy match output; det only advances in SHIFT.
  always_comb begin
    det_d       = det_q;
    match_pulse = 1'b0;
    unique case (det_q)
      DetS0: det_d = shift_bit ? DetS1 : DetS0;
      DetS1: det_d = shift_bit ? DetS1 : DetS2;
      DetS2: det_d = shift_bit ? DetS3 : DetS0;
      DetS3: det_d = shift_bit ? DetS1 : DetS2;
      default: det_d = DetS0;
    endcase
    if (state_q == StShift && det_q == DetS3 && !shift_bit) begin
      match_pulse = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      det_q       <= DetS0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            shreg_q    <= in_data;
            bit_cnt_q  <= BW'(W - 1);
            count_q    <= '0;
            if (!keep) begin
              det_q <= DetS0;
            end
            state_q    <= StShift;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StShift: begin
          det_q   <= det_d;
          shreg_q <= shreg_q << 1;
          if (match_pulse && count_q != CntMax) begin
            count_q <= count_q + 1'b1;
          end
          if (bit_cnt_q == '0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_count = count_q;
  assign out_hit   = (count_q != '0);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  // W=8, CW=4 instance
  logic       in_valid, in_ready, keep, out_valid, out_ready, out_hit, match_pulse, busy;
  logic [7:0] in_data;
  logic [3:0] out_count;
  // W=16, CW=2 instance
  logic        h_in_valid, h_in_ready, h_keep, h_out_valid, h_out_ready, h_out_hit;
  logic        h_match_pulse, h_busy;
  logic [15:0] h_in_data;
  logic [1:0]  h_out_count;

  int checks = 0;
  int errors = 0;

  // Reference model: sliding window over the scanned bit history.
  logic [3:0] m_hist = 4'b0;
  int         m_len  = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.W(8), .CW(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .keep(keep), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_hit(out_hit), .match_pulse(match_pulse), .busy(busy)
  );

  seq_scan_ctrl #(.W(16), .CW(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .keep(h_keep), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_count(h_out_count), .out_hit(h_out_hit), .match_pulse(h_match_pulse),
    .busy(h_busy)
  );

  // Scan one 8-bit word end to end, checking every cycle against the model.
  task automatic scan_word(input logic [7:0] data, input logic k, input int hold,
                           input bit poke, output int obs_cnt);
    logic [7:0] exp_vec, obs_vec;
    int         exp_n;
    logic [3:0] exp_cnt;
    logic       bad_ctl;
    if (!k) m_len = 0;
    exp_n = 0;
    for (int i = 0; i < 8; i++) begin
      m_hist = {m_hist[2:0], data[7-i]};
      m_len++;
      exp_vec[7-i] = (m_len >= 4 && m_hist == 4'b1010);
      if (exp_vec[7-i]) exp_n++;
    end
    exp_cnt = (exp_n > 15) ? 4'd15 : 4'(exp_n);

    @(posedge clk); #1;
    in_valid = 1'b1; in_data = data; keep = k;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL accept_idle: rdy/busy/ov=%b required 100", {in_ready, busy, out_valid});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'($urandom); keep = 1'($urandom);
    bad_ctl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs_vec[7-i] = match_pulse;
      if ({in_ready, busy, out_valid} !== 3'b010) bad_ctl = 1'b1;
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL pulse_pos data=%h keep=%b: got %b required %b", data, k, obs_vec, exp_vec);
    end
    checks++;
    if (bad_ctl) begin
      errors++;
      $display("FAIL shift_ctl data=%h: rdy/busy/ov not 010 during scan", data);
    end
    @(negedge clk);
    obs_cnt = int'(out_count);
    checks++;
    if ({out_valid, out_count, out_hit, match_pulse, busy, in_ready} !==
        {1'b1, exp_cnt, exp_cnt != 0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL result data=%h keep=%b: ov=%b cnt=%0d hit=%b mp=%b busy=%b rdy=%b required cnt=%0d",
               data, k, out_valid, out_count, out_hit, match_pulse, busy, in_ready, exp_cnt);
    end
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin in_valid = 1'b1; in_data = 8'h0A; keep = 1'b0; end
      @(negedge clk);
      checks++;
      if ({out_valid, out_count, out_hit, in_ready, busy, match_pulse} !==
          {1'b1, exp_cnt, exp_cnt != 0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold cycle %0d: ov=%b cnt=%0d rdy=%b required ov=1 cnt=%0d rdy=0",
                 h, out_valid, out_count, in_ready, exp_cnt);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL after_handshake: rdy/ov/busy=%b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 0; in_data = 0; keep = 0; out_ready = 0;
    h_in_valid = 0; h_in_data = 0; h_keep = 0; h_out_ready = 0;
    m_len = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_count, out_hit, match_pulse, busy} !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("FAIL reset8: rdy=%b ov=%b cnt=%0d hit=%b mp=%b busy=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_count, out_hit, match_pulse, busy);
    end
    checks++;
    if ({h_in_ready, h_out_valid, h_out_count, h_out_hit, h_match_pulse, h_busy} !== 7'b1_0_00_0_0_0) begin
      errors++;
      $display("FAIL reset16: rdy=%b ov=%b cnt=%0d required rdy=1 ov=0 cnt=0",
               h_in_ready, h_out_valid, h_out_count);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    int c;
    scan_word(8'h0A, 1'b0, 0, 1'b0, c);
    checks++;
    if (c != 1) begin errors++; $display("FAIL count_0a: got %0d required 1", c); end
    scan_word(8'hAA, 1'b0, 0, 1'b0, c);
    checks++;
    if (c != 3) begin errors++; $display("FAIL count_aa: got %0d required 3", c); end
  endtask

  task automatic test_span();
    int c;
    scan_word(8'h05, 1'b0, 0, 1'b0, c);
    scan_word(8'h00, 1'b1, 0, 1'b0, c);
    checks++;
    if (c != 1) begin errors++; $display("FAIL span_keep1: got %0d required 1", c); end
    scan_word(8'h05, 1'b0, 0, 1'b0, c);
    scan_word(8'h00, 1'b0, 0, 1'b0, c);
    checks++;
    if (c != 0) begin errors++; $display("FAIL span_keep0: got %0d required 0", c); end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    @(posedge clk); #1;
    h_in_valid = 1'b1; h_in_data = 16'hAAAA; h_keep = 1'b0;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (h_match_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 7) begin errors++; $display("FAIL sat_pulses: got %0d required 7", pulses); end
    @(negedge clk);
    checks++;
    if ({h_out_valid, h_out_count, h_out_hit} !== 4'b1_11_1) begin
      errors++;
      $display("FAIL sat_result: ov=%b cnt=%0d hit=%b required ov=1 cnt=3 hit=1",
               h_out_valid, h_out_count, h_out_hit);
    end
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({h_in_ready, h_out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL sat_handshake: rdy/ov=%b required 10", {h_in_ready, h_out_valid});
    end
  endtask

  task automatic test_backpressure();
    int c;
    scan_word(8'h0A, 1'b0, 5, 1'b1, c);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, in_ready, match_pulse} !== 3'b010) begin
        errors++;
        $display("FAIL no_spurious_scan: busy/rdy/mp=%b required 010", {busy, in_ready, match_pulse});
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hAA; keep = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, match_pulse} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid: ov/busy/rdy/mp=%b required 0010",
               {out_valid, busy, in_ready, match_pulse});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_len = 0;
    scan_word(8'h0A, 1'b1, 0, 1'b0, c);
    checks++;
    if (c != 1) begin errors++; $display("FAIL reset_no_carry: got %0d required 1", c); end
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 40; n++) begin
      scan_word(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), c);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_span();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
